// File: rtl/keypad_scanner_if.sv
// Pin-side bundle for the 4x4 hex keypad scanner: row strobes, column sense and
// the debounced key matrix presented to the CPU.
interface keypad_scanner_if;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keypad_matrix;
  logic        key_event;
  logic        scan_done;

  modport master (
    output row_n,
    output keypad_matrix,
    output key_event,
    output scan_done,
    input  col_n
  );

  modport slave (
    input  row_n,
    input  keypad_matrix,
    input  key_event,
    input  scan_done,
    output col_n
  );
endinterface

// File: rtl/keypad_scanner.sv
// Strobes the keypad rows one at a time, samples the synchronised columns, and debounces
// each of the 16 keys over whole scans before exposing them as keypad_matrix.
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  localparam int unsigned   SettleW    = $clog2(SETTLE_CYCLES);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DebTarget  = 4'(DEBOUNCE_COUNT);

  typedef enum logic [0:0] {
    StScan,
    StUpdate
  } state_e;

  // Physical position (row, col) to CHIP-8 key index.
  function automatic logic [3:0] key_idx(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    idx = 4'h0;
    case ({row, col})
      4'b00_00: idx = 4'h1;
      4'b00_01: idx = 4'h2;
      4'b00_10: idx = 4'h3;
      4'b00_11: idx = 4'hC;
      4'b01_00: idx = 4'h4;
      4'b01_01: idx = 4'h5;
      4'b01_10: idx = 4'h6;
      4'b01_11: idx = 4'hD;
      4'b10_00: idx = 4'h7;
      4'b10_01: idx = 4'h8;
      4'b10_10: idx = 4'h9;
      4'b10_11: idx = 4'hE;
      4'b11_00: idx = 4'hA;
      4'b11_01: idx = 4'h0;
      4'b11_10: idx = 4'hB;
      4'b11_11: idx = 4'hF;
      default:  idx = 4'h0;
    endcase
    return idx;
  endfunction

  logic [3:0]         r_col_meta;
  logic [3:0]         r_col_sync;
  state_e             r_state;
  logic [SettleW-1:0] r_settle;
  logic [1:0]         r_row;
  logic [3:0]         r_row_n;
  logic [15:0]        r_raw;
  logic [15:0]        r_stable;
  logic [3:0]         r_cnt [16];
  logic               r_key_event;

  state_e             w_state_d;
  logic [SettleW-1:0] w_settle_d;
  logic [1:0]         w_row_d;
  logic [3:0]         w_row_n_d;
  logic [15:0]        w_raw_d;
  logic [15:0]        w_stable_d;
  logic [3:0]         w_cnt_d [16];
  logic               w_key_event_d;
  logic               w_scan_done;

  always_comb begin
    w_state_d     = r_state;
    w_settle_d    = r_settle;
    w_row_d       = r_row;
    w_row_n_d     = r_row_n;
    w_raw_d       = r_raw;
    w_stable_d    = r_stable;
    w_cnt_d       = r_cnt;
    w_key_event_d = 1'b0;
    w_scan_done   = 1'b0;

    unique case (r_state)
      StScan: begin
        if (r_settle == SettleLast) begin
          for (int c = 0; c < 4; c++) begin
            w_raw_d[key_idx(r_row, 2'(c))] = ~r_col_sync[c];
          end
          w_settle_d = '0;
          if (r_row == 2'd3) begin
            w_row_d   = 2'd0;
            w_row_n_d = 4'b1110;
            w_state_d = StUpdate;
          end else begin
            w_row_d   = r_row + 2'd1;
            w_row_n_d = {r_row_n[2:0], r_row_n[3]};
          end
        end else begin
          w_settle_d = r_settle + 1'b1;
        end
      end

      StUpdate: begin
        w_scan_done = 1'b1;
        w_state_d   = StScan;
        // Any scan that agrees with the stable value restarts that key's count.
        for (int k = 0; k < 16; k++) begin
          if (r_raw[k] == r_stable[k]) begin
            w_cnt_d[k] = 4'd0;
          end else if (r_cnt[k] + 4'd1 == DebTarget) begin
            w_stable_d[k] = ~r_stable[k];
            w_cnt_d[k]    = 4'd0;
          end else begin
            w_cnt_d[k] = r_cnt[k] + 4'd1;
          end
        end
        w_key_event_d = (w_stable_d != r_stable);
      end

      default: w_state_d = StScan;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_meta  <= 4'hF;
      r_col_sync  <= 4'hF;
      r_state     <= StScan;
      r_settle    <= '0;
      r_row       <= 2'd0;
      r_row_n     <= 4'b1110;
      r_raw       <= '0;
      r_stable    <= '0;
      r_cnt       <= '{default: 4'd0};
      r_key_event <= 1'b0;
    end else begin
      r_col_meta  <= bus.col_n;
      r_col_sync  <= r_col_meta;
      r_state     <= w_state_d;
      r_settle    <= w_settle_d;
      r_row       <= w_row_d;
      r_row_n     <= w_row_n_d;
      r_raw       <= w_raw_d;
      r_stable    <= w_stable_d;
      r_cnt       <= w_cnt_d;
      r_key_event <= w_key_event_d;
    end
  end

  assign bus.row_n         = r_row_n;
  assign bus.keypad_matrix = r_stable;
  assign bus.key_event     = r_key_event;
  assign bus.scan_done     = w_scan_done;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised scoreboard bench for keypad_scanner: a simulated keypad drives the columns,
// a per-scan debounce model predicts keypad_matrix and key_event after every scan.
module tb_keypad_scanner;
  localparam int unsigned Settle = 8;
  localparam int unsigned Deb    = 3;
  localparam int unsigned Period = 4 * Settle + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SETTLE_CYCLES (Settle),
    .DEBOUNCE_COUNT(Deb)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (kp)
  );

  // Key printed at row r, column c of the physical keypad.
  int km [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

  logic [15:0] held = '0;
  logic [3:0]  w_col;

  always_comb begin
    w_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (kp.row_n[r] == 1'b0 && held[km[r][c]]) w_col[c] = 1'b0;
      end
    end
  end
  assign kp.col_n = w_col;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each key needs Deb consecutive disagreeing scans to flip.
  int          streak [16];
  logic [15:0] model_stable;
  logic [15:0] exp_q [$];

  task automatic model_reset();
    for (int k = 0; k < 16; k++) streak[k] = 0;
    model_stable = '0;
    exp_q.delete();
  endtask

  task automatic model_scan(input logic [15:0] keys);
    for (int k = 0; k < 16; k++) begin
      if (keys[k] == model_stable[k]) begin
        streak[k] = 0;
      end else begin
        streak[k] = streak[k] + 1;
        if (streak[k] >= int'(Deb)) begin
          model_stable[k] = keys[k];
          streak[k] = 0;
        end
      end
    end
    exp_q.push_back(model_stable);
  endtask

  task automatic wait_scan_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < int'(Period) + 10; i++) begin
      @(negedge clk);
      if (kp.scan_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("scan_done_timeout", 32'd0, 32'd1);
  endtask

  // Keys change during the UPDATE cycle, so the whole following scan sees them.
  task automatic run_scan(input logic [15:0] keys);
    held = keys;
    model_scan(keys);
    wait_scan_done();
  endtask

  // Monitor
  bit          pending   = 1'b0;
  bit          have_prev = 1'b0;
  int          cyc       = 0;
  int          row_bad   = 0;
  int          spurious  = 0;
  logic [15:0] prev_exp  = '0;

  always @(negedge clk) begin
    logic [15:0] exp_v;
    logic [3:0]  exp_row;
    if (reset) begin
      pending   = 1'b0;
      have_prev = 1'b0;
      cyc       = 0;
      row_bad   = 0;
      prev_exp  = '0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          check("queue_underflow", 32'd0, 32'd1);
        end else begin
          exp_v = exp_q.pop_front();
          check("keypad_matrix", 32'(kp.keypad_matrix), 32'(exp_v));
          check("key_event", 32'(kp.key_event), 32'(exp_v != prev_exp));
          prev_exp = exp_v;
        end
      end else if (kp.key_event) begin
        spurious++;
      end
      cyc++;
      if (have_prev) begin
        if (cyc >= int'(Period)) exp_row = 4'b1110;
        else exp_row = ~(4'b0001 << ((cyc - 1) / int'(Settle)));
        if (kp.row_n !== exp_row) row_bad++;
      end
      if (kp.scan_done) begin
        if (have_prev) begin
          check("scan_period", 32'(cyc), 32'(Period));
          check("row_seq", 32'(row_bad), 32'd0);
        end
        have_prev = 1'b1;
        cyc       = 0;
        row_bad   = 0;
        pending   = 1'b1;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_row_n", 32'(kp.row_n), 32'h0000_000E);
    check("rst_matrix", 32'(kp.keypad_matrix), 32'd0);
    check("rst_key_event", 32'(kp.key_event), 32'd0);
    check("rst_scan_done", 32'(kp.scan_done), 32'd0);
  endtask

  initial begin
    logic [15:0] keys;
    int          n;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;

    repeat (2) run_scan(16'h0000);
    // Key 5 press and release.
    repeat (5) run_scan(16'h0020);
    repeat (4) run_scan(16'h0000);
    // Key C bounce shorter than the debounce window.
    repeat (2) run_scan(16'h1000);
    repeat (4) run_scan(16'h0000);
    // Keys A and F together.
    repeat (4) run_scan(16'h8400);
    repeat (4) run_scan(16'h0000);
    // Random key sets held for random numbers of scans.
    for (int i = 0; i < 25; i++) begin
      keys = 16'($urandom & $urandom & $urandom);
      n    = $urandom_range(1, 5);
      repeat (n) run_scan(keys);
    end
    repeat (4) run_scan(16'h0000);

    // Key 0 held, then reset in the middle of row 2.
    repeat (4) run_scan(16'h0001);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) run_scan(16'h0001);
    repeat (3) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("spurious_key_event", 32'(spurious), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
